// File: rtl/battle_turn_engine.sv
// rtl/battle_turn_engine.sv - one attack turn through a shared damage datapath, owning both HP registers
// LOAD -> SCALE -> APPLY -> CHECK; END holds a decided battle until new_battle.
module battle_turn_engine #(
    parameter int HP_W   = 8,
    parameter int MAX_HP = 100,
    parameter int PWR_W  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             new_battle,
    input  logic             start,
    input  logic             attacker,
    input  logic [PWR_W-1:0] move_power,
    input  logic [1:0]       effectiveness,
    output logic             busy,
    output logic             done,
    output logic [HP_W-1:0]  damage,
    output logic [HP_W-1:0]  player_hp,
    output logic [HP_W-1:0]  ai_hp,
    output logic             victory,
    output logic             loss
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SCALE, S_APPLY, S_CHECK, S_END
    } state_t;

    localparam int BASE_W = PWR_W + 2;
    localparam int SC_W   = PWR_W + 3;
    localparam int WW     = (SC_W > HP_W) ? SC_W : HP_W;
    localparam logic [HP_W-1:0] HP_INIT = HP_W'(MAX_HP);
    localparam logic [WW-1:0]   DMG_SAT = WW'({HP_W{1'b1}});

    state_t              state_q, state_d;
    logic                atk_q, atk_d;
    logic [PWR_W-1:0]    pwr_q, pwr_d;
    logic [1:0]          eff_q, eff_d;
    logic [BASE_W-1:0]   base_q, base_d;
    logic [HP_W-1:0]     damage_q, damage_d;
    logic [HP_W-1:0]     player_hp_q, player_hp_d;
    logic [HP_W-1:0]     ai_hp_q, ai_hp_d;
    logic                victory_q, victory_d;
    logic                loss_q, loss_d;

    logic [WW-1:0]       scaled_w;
    logic [HP_W-1:0]     damage_sat;
    logic [HP_W-1:0]     def_hp;
    logic                reinit;

    // Widened before scaling so the x2 case cannot wrap before saturation.
    always_comb begin
        scaled_w = '0;
        case (eff_q)
            2'd0:    scaled_w = '0;
            2'd1:    scaled_w = WW'(base_q >> 1);
            2'd2:    scaled_w = WW'(base_q);
            default: scaled_w = WW'(base_q) << 1;
        endcase
        damage_sat = (scaled_w > DMG_SAT) ? {HP_W{1'b1}} : scaled_w[HP_W-1:0];
    end

    assign def_hp = atk_q ? player_hp_q : ai_hp_q;

    always_comb begin
        state_d     = state_q;
        atk_d       = atk_q;
        pwr_d       = pwr_q;
        eff_d       = eff_q;
        base_d      = base_q;
        damage_d    = damage_q;
        player_hp_d = player_hp_q;
        ai_hp_d     = ai_hp_q;
        victory_d   = victory_q;
        loss_d      = loss_q;
        busy        = 1'b0;
        done        = 1'b0;
        reinit      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (new_battle) begin
                    reinit = 1'b1;
                end else if (start) begin
                    atk_d   = attacker;
                    pwr_d   = move_power;
                    eff_d   = effectiveness;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                busy    = 1'b1;
                base_d  = {pwr_q, 2'b00};
                state_d = S_SCALE;
            end
            S_SCALE: begin
                busy     = 1'b1;
                damage_d = damage_sat;
                state_d  = S_APPLY;
            end
            S_APPLY: begin
                busy = 1'b1;
                if (atk_q)
                    player_hp_d = (player_hp_q > damage_q) ? player_hp_q - damage_q : '0;
                else
                    ai_hp_d = (ai_hp_q > damage_q) ? ai_hp_q - damage_q : '0;
                state_d = S_CHECK;
            end
            S_CHECK: begin
                busy = 1'b1;
                done = 1'b1;
                if (def_hp == '0) begin
                    if (atk_q) loss_d = 1'b1;
                    else       victory_d = 1'b1;
                    state_d = S_END;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_END: begin
                if (new_battle) begin
                    reinit  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (reinit) begin
            player_hp_d = HP_INIT;
            ai_hp_d     = HP_INIT;
            damage_d    = '0;
            victory_d   = 1'b0;
            loss_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            atk_q       <= 1'b0;
            pwr_q       <= '0;
            eff_q       <= '0;
            base_q      <= '0;
            damage_q    <= '0;
            player_hp_q <= HP_INIT;
            ai_hp_q     <= HP_INIT;
            victory_q   <= 1'b0;
            loss_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            atk_q       <= atk_d;
            pwr_q       <= pwr_d;
            eff_q       <= eff_d;
            base_q      <= base_d;
            damage_q    <= damage_d;
            player_hp_q <= player_hp_d;
            ai_hp_q     <= ai_hp_d;
            victory_q   <= victory_d;
            loss_q      <= loss_d;
        end
    end

    assign damage    = damage_q;
    assign player_hp = player_hp_q;
    assign ai_hp     = ai_hp_q;
    assign victory   = victory_q;
    assign loss      = loss_q;

endmodule

// File: tb/tb_battle_turn_engine.sv
// tb/tb_battle_turn_engine.sv - randomized self-checking bench for battle_turn_engine
module tb_battle_turn_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       new_battle = 1'b0;
    logic       start = 1'b0;
    logic       attacker = 1'b0;
    logic [3:0] move_power = '0;
    logic [1:0] effectiveness = '0;
    logic       busy, done, victory, loss;
    logic [7:0] damage, player_hp, ai_hp;

    int tests = 0;
    int fails = 0;

    // Reference state of the battle
    int  m_php, m_ahp, m_dmg;
    bit  m_vic, m_loss;

    always #5 clk = ~clk;

    battle_turn_engine dut (
        .clk(clk), .reset(reset), .new_battle(new_battle), .start(start),
        .attacker(attacker), .move_power(move_power), .effectiveness(effectiveness),
        .busy(busy), .done(done), .damage(damage), .player_hp(player_hp),
        .ai_hp(ai_hp), .victory(victory), .loss(loss)
    );

    function automatic int model_damage(input int p, input int e);
        int v;
        case (e)
            0:       v = 0;
            1:       v = (p * 4) / 2;
            2:       v = p * 4;
            default: v = p * 8;
        endcase
        return (v > 255) ? 255 : v;
    endfunction

    task automatic model_init();
        m_php = 100; m_ahp = 100; m_dmg = 0; m_vic = 0; m_loss = 0;
    endtask

    task automatic pulse_new_battle();
        new_battle = 1'b1;
        @(negedge clk);
        new_battle = 1'b0;
        model_init();
    endtask

    // One full turn from IDLE; checks the cycle-by-cycle timing and results
    task automatic run_turn(input logic a, input int p, input int e);
        int exp_def, exp_att;
        m_dmg = model_damage(p, e);
        if (a == 1'b0) begin
            exp_def = (m_ahp > m_dmg) ? m_ahp - m_dmg : 0;
            exp_att = m_php;
        end else begin
            exp_def = (m_php > m_dmg) ? m_php - m_dmg : 0;
            exp_att = m_ahp;
        end
        attacker = a; move_power = 4'(p); effectiveness = 2'(e); start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        attacker = ~a; move_power = 4'($urandom); effectiveness = 2'($urandom);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            tests++;
            if (busy !== (c <= 4)) begin
                fails++; $display("FAIL busy_c%0d: got %b want %b", c, busy, (c <= 4));
            end
            tests++;
            if (done !== (c == 4)) begin
                fails++; $display("FAIL done_c%0d: got %b want %b", c, done, (c == 4));
            end
            if (c == 3) begin
                tests++;
                if (damage !== 8'(m_dmg)) begin
                    fails++; $display("FAIL damage p=%0d e=%0d: got %0d want %0d", p, e, damage, m_dmg);
                end
            end
            if (c == 4) begin
                tests++;
                if ((a ? player_hp : ai_hp) !== 8'(exp_def)) begin
                    fails++; $display("FAIL defender_hp a=%0d: got %0d want %0d", a, (a ? player_hp : ai_hp), exp_def);
                end
                tests++;
                if ((a ? ai_hp : player_hp) !== 8'(exp_att)) begin
                    fails++; $display("FAIL attacker_hp a=%0d: got %0d want %0d", a, (a ? ai_hp : player_hp), exp_att);
                end
            end
        end
        if (a == 1'b0) begin m_ahp = exp_def; if (exp_def == 0) m_vic = 1; end
        else           begin m_php = exp_def; if (exp_def == 0) m_loss = 1; end
        tests++;
        if (victory !== m_vic || loss !== m_loss) begin
            fails++; $display("FAIL status: got v=%b l=%b want v=%b l=%b", victory, loss, m_vic, m_loss);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        model_init();
        tests++;
        if (player_hp !== 8'd100 || ai_hp !== 8'd100 || damage !== 8'd0 ||
            busy !== 1'b0 || done !== 1'b0 || victory !== 1'b0 || loss !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: php=%0d ahp=%0d dmg=%0d busy=%b done=%b v=%b l=%b",
                     player_hp, ai_hp, damage, busy, done, victory, loss);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        run_turn(1'b0, 5, 2);
        tests++;
        if (ai_hp !== 8'd80 || player_hp !== 8'd100) begin
            fails++; $display("FAIL basic_hp: got ai=%0d pl=%0d want 80/100", ai_hp, player_hp);
        end
    endtask

    task automatic test_knockout();
        int busy_seen = 0, done_seen = 0;
        run_turn(1'b1, 15, 3);
        tests++;
        if (damage !== 8'd120 || player_hp !== 8'd0 || loss !== 1'b1 || victory !== 1'b0) begin
            fails++; $display("FAIL knockout: dmg=%0d php=%0d l=%b v=%b", damage, player_hp, loss, victory);
        end
        start = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_seen++;
            if (done) done_seen++;
        end
        tests++;
        if (busy_seen != 0 || done_seen != 0 || player_hp !== 8'd0 || loss !== 1'b1) begin
            fails++; $display("FAIL end_holds: busy_cycles=%0d done_cycles=%0d php=%0d l=%b want 0/0/0/1",
                              busy_seen, done_seen, player_hp, loss);
        end
        pulse_new_battle();
        tests++;
        if (player_hp !== 8'd100 || ai_hp !== 8'd100 || loss !== 1'b0 || victory !== 1'b0) begin
            fails++; $display("FAIL new_battle_from_end: php=%0d ahp=%0d l=%b v=%b", player_hp, ai_hp, loss, victory);
        end
    endtask

    task automatic test_effectiveness();
        run_turn(1'b0, 3, 1);
        run_turn(1'b0, 3, 0);
        tests++;
        if (damage !== 8'd0 || ai_hp !== 8'd94) begin
            fails++; $display("FAIL eff0: dmg=%0d ahp=%0d want 0/94", damage, ai_hp);
        end
    endtask

    task automatic test_hp_floor();
        pulse_new_battle();
        run_turn(1'b0, 15, 2);
        run_turn(1'b0, 15, 1);
        tests++;
        if (ai_hp !== 8'd10) begin
            fails++; $display("FAIL setup_ai10: got %0d want 10", ai_hp);
        end
        run_turn(1'b0, 5, 2);
        tests++;
        if (ai_hp !== 8'd0 || victory !== 1'b1 || loss !== 1'b0) begin
            fails++; $display("FAIL hp_floor: ahp=%0d v=%b l=%b want 0/1/0", ai_hp, victory, loss);
        end
        pulse_new_battle();
    endtask

    task automatic test_ignore_busy();
        int busy_seen = 0, done_seen = 0;
        pulse_new_battle();
        attacker = 1'b0; move_power = 4'd5; effectiveness = 2'd2; start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 7; c++) begin
            @(negedge clk);
            if (busy) busy_seen++;
            if (done) done_seen++;
            if (c == 1) begin attacker = 1'b1; move_power = 4'd15; effectiveness = 2'd3; end
            if (c == 2) new_battle = 1'b1;
            if (c == 3) new_battle = 1'b0;
            if (c == 4) start = 1'b0;
        end
        m_ahp = 80; m_dmg = 20;
        tests++;
        if (busy_seen != 4 || done_seen != 1) begin
            fails++; $display("FAIL single_turn: busy_cycles=%0d done_cycles=%0d want 4/1", busy_seen, done_seen);
        end
        tests++;
        if (ai_hp !== 8'd80 || player_hp !== 8'd100 || damage !== 8'd20) begin
            fails++; $display("FAIL no_reinit_busy: ahp=%0d php=%0d dmg=%0d want 80/100/20", ai_hp, player_hp, damage);
        end
        busy_seen = 0;
        start = 1'b1; new_battle = 1'b1;
        @(negedge clk);
        start = 1'b0; new_battle = 1'b0;
        model_init();
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        tests++;
        if (busy_seen != 0 || ai_hp !== 8'd100 || damage !== 8'd0) begin
            fails++; $display("FAIL nb_wins: busy_cycles=%0d ahp=%0d dmg=%0d want 0/100/0", busy_seen, ai_hp, damage);
        end
    endtask

    task automatic test_reset_midturn();
        int done_seen = 0;
        run_turn(1'b1, 7, 2);
        attacker = 1'b0; move_power = 4'd9; effectiveness = 2'd3; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_init();
        tests++;
        if (player_hp !== 8'd100 || ai_hp !== 8'd100 || damage !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL reset_midturn: php=%0d ahp=%0d dmg=%0d busy=%b done=%b",
                              player_hp, ai_hp, damage, busy, done);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        tests++;
        if (done_seen != 0) begin
            fails++; $display("FAIL aborted_turn_activity: got %0d cycles want 0", done_seen);
        end
        run_turn(1'b0, 2, 2);
    endtask

    task automatic test_random();
        pulse_new_battle();
        for (int i = 0; i < 40; i++) begin
            if (m_vic || m_loss) pulse_new_battle();
            run_turn(1'($urandom), int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_back_to_back();
        pulse_new_battle();
        run_turn(1'b0, 1, 2);
        run_turn(1'b1, 2, 3);
        run_turn(1'b0, 3, 1);
        tests++;
        if (ai_hp !== 8'd90 || player_hp !== 8'd84) begin
            fails++; $display("FAIL back_to_back: ahp=%0d php=%0d want 90/84", ai_hp, player_hp);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_basic();
        test_knockout();
        test_effectiveness();
        test_hp_floor();
        test_ignore_busy();
        test_reset_midturn();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
